decoder_pipe: RTL and testbench
===============================

# decoder_pipe

Parametrised, handshaked successor to the combinational N-to-2^N decoder. Accepts a binary code plus enable and mode on a valid/ready input. Produces a registered one-hot, one-cold or thermometer pattern on a valid/ready output, with a 2-entry skid buffer for full throughput under back-pressure. Sits between address/select generators and banked register files or memory-bank enables, where the pattern must be registered and flow-controlled.

## Interface
- `SIZE`, 3, code width in bits (1..8)
- `WIDTH`, `1 << SIZE`, output width; any value 2..2^SIZE; codes >= `WIDTH` are out of range
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  block can accept a beat
- `in_code`  in  SIZE  binary code
- `in_en`  in  1  decode enable; 0 selects the inactive pattern
- `in_mode`  in  2  0 one-hot, 1 thermometer-up, 2 one-cold, 3 thermometer-down
- `out_valid`  out  1  output beat present
- `out_ready`  in  1  consumer accepts beat
- `out_dec`  out  WIDTH  decoded pattern
- `out_err`  out  1  beat had an out-of-range code (`in_en`=1, `in_code` >= `WIDTH`)

## Operation
- Pattern for code c, with en=1 and c < WIDTH:
  - one-hot: bit k = (k==c)
  - thermometer-up: bit k = (k<=c)
  - one-cold: bit k = (k!=c)
  - thermometer-down: bit k = (k>=c)
- Inactive pattern: all zeros for modes 0/1/3, all ones for mode 2.
- en=0: inactive pattern, `out_err`=0, regardless of code.
- en=1 and c >= WIDTH: inactive pattern, `out_err`=1. Code zero-extended for comparison, no truncation or wrap.
- Beat transfers on input when `in_valid & in_ready`; on output when `out_valid & out_ready`.
- Pattern, err and mode are computed at input acceptance and stored; stored beats are unaffected by later input changes.
- State machine on buffer occupancy:
  - EMPTY: `out_valid`=0; accept → ONE
  - ONE: output register full; accept without drain → TWO; drain without accept → EMPTY; accept+drain → ONE, new beat moves into output register
  - TWO: skid also full, `in_ready`=0; drain → ONE, skid beat moves into output register
- `in_ready` = not TWO, driven from registered state only, no combinational path from `out_ready`.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- `in_valid` deasserted with `in_ready` high is a no-op. Asserting `in_valid` in TWO has no effect; the beat is held by the producer.

## Timing
- Latency: beat accepted in cycle t is on `out_dec`/`out_valid` in cycle t+1 when the buffer was EMPTY, or after older beats drain.
- Throughput: one beat per cycle while `out_ready`=1.
- Back-pressure: `out_ready` low in cycle t while in ONE with an accept → TWO at t+1, `in_ready` low from t+1.
- Reset, asynchronous assert and synchronous-safe release:
  - state EMPTY, `out_valid`=0, `out_dec`=0, `out_err`=0, skid cleared
  - `in_ready`=1 during and after reset
- Reset mid-operation discards both buffered beats immediately.
- `out_dec` and `out_err` are stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Package `decoder_pkg`:
  - `decode_mode_e` enum (`DEC_ONEHOT`, `DEC_THERM_UP`, `DEC_ONECOLD`, `DEC_THERM_DN`)
  - `buf_state_e` enum (`EMPTY`, `ONE`, `TWO`)
- Sub-module `decoder_pattern` (parameters `SIZE`, `WIDTH`): purely combinational code/en/mode → pattern + err. Reusable by other blocks. `decoder_pipe` instantiates it once at the input.
- Top holds the state register, output register and skid register (pattern + err each).

## Test plan
- SIZE=3, WIDTH=8, `out_ready`=1, modes 0..3 with code 5 → `out_dec` 0x20, 0x3F, 0xDF, 0xE0 one cycle after each accept, `out_err`=0.
- SIZE=3, WIDTH=6, en=1, code 6 and code 7, mode 0 → `out_dec`=0x00, `out_err`=1; mode 2 → `out_dec`=0x3F, `out_err`=1.
- en=0, code 2, each mode → 0x00/0x00/0xFF/0x00, `out_err`=0.
- Stream codes 0..7 back-to-back, `out_ready` low for cycles 3–5:
  - `in_ready` falls one cycle after the stall enters TWO
  - output order 0x01,0x02,…,0x80 with no loss or duplicate
  - `out_dec` stable during the stall
- Fill to TWO, then drop `rst_n` asynchronously mid-cycle → `out_valid`=0, `out_dec`=0 immediately. After release, the first accept is the first output; old beats never appear.
- Random valid/ready over 10k beats with scoreboard against a reference pattern model → zero mismatches, `in_ready` never depends combinationally on `out_ready`.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types for the handshaked code-to-pattern decoder.
// Pattern modes and skid-buffer occupancy states.
package decoder_pkg;

  localparam int DEC_SIZE_MAX = 8;

  typedef enum logic [1:0] {
    DEC_ONEHOT   = 2'd0,
    DEC_THERM_UP = 2'd1,
    DEC_ONECOLD  = 2'd2,
    DEC_THERM_DN = 2'd3
  } decode_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Pattern emitted when nothing is selected.
  function automatic logic idle_bit(
    input decode_mode_e mode
  );
    return (mode == DEC_ONECOLD);
  endfunction

endpackage

// File: rtl/decoder_pattern.sv
// Combinational code/en/mode -> WIDTH-bit pattern plus range error.
// Ports: code, en, mode in; dec (pattern), err (code >= WIDTH) out.
module decoder_pattern
  import decoder_pkg::*;
#(
  parameter int SIZE  = 3,
  parameter int WIDTH = 1 << SIZE
) (
  input  logic [SIZE-1:0]  code,
  input  logic             en,
  input  decode_mode_e     mode,
  output logic [WIDTH-1:0] dec,
  output logic             err
);

  logic [31:0] idx;
  logic        in_range;

  // Zero-extend so codes beyond WIDTH never wrap into range.
  assign idx      = 32'(code);
  assign in_range = (idx < 32'(WIDTH));

  always_comb begin
    err = en && !in_range;
    dec = {WIDTH{idle_bit(mode)}};
    if (en && in_range) begin
      for (int k = 0; k < WIDTH; k++) begin
        unique case (mode)
          DEC_ONEHOT:   dec[k] = (32'(k) == idx);
          DEC_THERM_UP: dec[k] = (32'(k) <= idx);
          DEC_ONECOLD:  dec[k] = (32'(k) != idx);
          DEC_THERM_DN: dec[k] = (32'(k) >= idx);
          default:      dec[k] = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Registered, valid/ready decoder with a 2-entry skid buffer.
// Ports: clk, rst_n; in_valid/in_ready/in_code/in_en/in_mode;
// out_valid/out_ready/out_dec/out_err.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int SIZE  = 3,
  parameter int WIDTH = 1 << SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_code,
  input  logic             in_en,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_dec,
  output logic             out_err
);

  typedef struct packed {
    logic [WIDTH-1:0] dec;
    logic             err;
  } beat_t;

  buf_state_e state_q, state_d;

  beat_t in_beat;
  beat_t out_q;
  beat_t skid_q;

  logic [WIDTH-1:0] pat_dec;
  logic             pat_err;

  logic acc;
  logic drain;
  logic ld_out_in;
  logic ld_out_skid;
  logic ld_skid;

  decoder_pattern #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_pattern (
    .code (in_code),
    .en   (in_en),
    .mode (decode_mode_e'(in_mode)),
    .dec  (pat_dec),
    .err  (pat_err)
  );

  assign in_beat = '{dec: pat_dec, err: pat_err};

  // Both handshake outputs come from the state register only.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);

  assign acc   = in_valid & in_ready;
  assign drain = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d   = ONE;
          ld_out_in = 1'b1;
        end
      end
      ONE: begin
        unique case (1'b1)
          acc && drain: begin
            ld_out_in = 1'b1;
          end
          acc && !drain: begin
            state_d = TWO;
            ld_skid = 1'b1;
          end
          !acc && drain: begin
            state_d = EMPTY;
          end
          default: begin
            state_d = ONE;
          end
        endcase
      end
      TWO: begin
        if (drain) begin
          state_d     = ONE;
          ld_out_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out_in) begin
        out_q <= in_beat;
      end else if (ld_out_skid) begin
        out_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_beat;
      end
    end
  end

  assign out_dec = out_q.dec;
  assign out_err = out_q.err;

endmodule

// File: tb/tb_decoder_pipe.sv
// Scoreboard bench for decoder_pipe: WIDTH=8 and WIDTH=6 instances.
// Driver pushes expected beats; negedge monitors pop and compare.
module tb_decoder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a_valid = 1'b0, a_rdy, a_en = 1'b0;
  logic [2:0] a_code = '0;
  logic [1:0] a_mode = '0;
  logic       a_ovalid, a_ordy = 1'b1, a_err;
  logic [7:0] a_dec;

  logic       b_valid = 1'b0, b_rdy, b_en = 1'b0;
  logic [2:0] b_code = '0;
  logic [1:0] b_mode = '0;
  logic       b_ovalid, b_ordy = 1'b1, b_err;
  logic [5:0] b_dec;

  int n_checks = 0;
  int n_pass = 0;

  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];

  int         occ = 0;
  bit         stall = 0;
  logic [8:0] held = '0;
  bit         rnd_on = 0;

  always #5 clk = ~clk;

  decoder_pipe #(.SIZE(3), .WIDTH(8)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_valid),
    .in_ready  (a_rdy),
    .in_code   (a_code),
    .in_en     (a_en),
    .in_mode   (a_mode),
    .out_valid (a_ovalid),
    .out_ready (a_ordy),
    .out_dec   (a_dec),
    .out_err   (a_err)
  );

  decoder_pipe #(.SIZE(3), .WIDTH(6)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_valid),
    .in_ready  (b_rdy),
    .in_code   (b_code),
    .in_en     (b_en),
    .in_mode   (b_mode),
    .out_valid (b_ovalid),
    .out_ready (b_ordy),
    .out_dec   (b_dec),
    .out_err   (b_err)
  );

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                  nm, act, want, $time);
  endtask

  // Independent reference: built from shifts and masks.
  function automatic logic [8:0] ref_pat(input int c, input bit en,
                                          input int m, input int w);
    logic [7:0] mask, oh, idle, r;
    mask = 8'((9'd1 << w) - 9'd1);
    idle = (m == 2) ? mask : 8'h00;
    if (!en) return {1'b0, idle};
    if (c >= w) return {1'b1, idle};
    oh = 8'(9'd1 << c);
    case (m)
      0: r = oh;
      1: r = 8'((9'd2 << c) - 9'd1);
      2: r = mask & ~oh;
      default: r = mask & ~(oh - 8'd1);
    endcase
    return {1'b0, r};
  endfunction

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send_a(input logic [2:0] c, input logic e,
                        input logic [1:0] m, input logic [8:0] x);
    int t = 0;
    bit done = 0;
    a_valid = 1'b1; a_code = c; a_en = e; a_mode = m;
    while (!done) begin
      @(negedge clk);
      if (a_rdy) begin
        exp_a.push_back(x);
        done = 1;
      end else if (++t > 200) begin
        chk(0, "a_accept_timeout", 0, 1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] c, input logic e,
                        input logic [1:0] m, input logic [8:0] x);
    b_valid = 1'b1; b_code = c; b_en = e; b_mode = m;
    @(negedge clk);
    if (b_rdy) exp_b.push_back(x);
    else chk(0, "b_in_ready", 0, 1);
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk(exp_a.size() == 0, "a_drain", exp_a.size(), 0);
    chk(exp_b.size() == 0, "b_drain", exp_b.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      occ = 0;
      stall = 0;
    end else begin
      chk(a_rdy == (occ < 2), "a_in_ready", a_rdy, occ < 2);
      chk(a_ovalid == (occ > 0), "a_out_valid", a_ovalid, occ > 0);
      if (stall && a_ovalid)
        chk({a_err, a_dec} == held, "a_stable", {a_err, a_dec}, held);
      if (a_ovalid && a_ordy) begin
        if (exp_a.size() == 0) begin
          chk(0, "a_unexpected", {a_err, a_dec}, 0);
        end else begin
          e = exp_a.pop_front();
          chk({a_err, a_dec} == e, "a_beat", {a_err, a_dec}, e);
        end
      end
      stall = a_ovalid && !a_ordy;
      held = {a_err, a_dec};
      occ = occ + ((a_valid && occ < 2) ? 1 : 0)
                - ((occ > 0 && a_ordy) ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && b_ovalid && b_ordy) begin
      if (exp_b.size() == 0) begin
        chk(0, "b_unexpected", {b_err, 2'b00, b_dec}, 0);
      end else begin
        e = exp_b.pop_front();
        chk({b_err, 2'b00, b_dec} == e, "b_beat",
            {b_err, 2'b00, b_dec}, e);
      end
    end
  end

  logic [8:0] v_mode5 [4] = '{9'h020, 9'h03F, 9'h0DF, 9'h0E0};
  logic [8:0] v_dis   [4] = '{9'h000, 9'h000, 9'h0FF, 9'h000};
  logic [8:0] v_strm  [8] = '{9'h001, 9'h002, 9'h004, 9'h008,
                              9'h010, 9'h020, 9'h040, 9'h080};

  initial begin
    #2;
    chk(a_rdy == 1'b1, "rst_in_ready", a_rdy, 1);
    chk(a_ovalid == 1'b0, "rst_out_valid", a_ovalid, 0);
    chk(a_dec == 8'h00, "rst_out_dec", a_dec, 0);
    chk(a_err == 1'b0, "rst_out_err", a_err, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk(a_rdy == 1'b1, "post_rst_in_ready", a_rdy, 1);

    for (int m = 0; m < 4; m++)
      send_a(3'd5, 1'b1, 2'(m), v_mode5[m]);
    for (int m = 0; m < 4; m++)
      send_a(3'd2, 1'b0, 2'(m), v_dis[m]);

    send_b(3'd6, 1'b1, 2'd0, 9'h100);
    send_b(3'd7, 1'b1, 2'd0, 9'h100);
    send_b(3'd6, 1'b1, 2'd2, 9'h13F);
    send_b(3'd7, 1'b1, 2'd2, 9'h13F);
    send_b(3'd5, 1'b1, 2'd0, 9'h020);
    send_b(3'd0, 1'b1, 2'd3, 9'h03F);
    send_b(3'd2, 1'b1, 2'd1, 9'h007);
    send_b(3'd7, 1'b0, 2'd2, 9'h03F);
    wait_drain();

    fork
      for (int i = 0; i < 8; i++)
        send_a(3'(i), 1'b1, 2'd0, v_strm[i]);
      begin
        repeat (3) @(posedge clk);
        #1 a_ordy = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_ordy = 1'b1;
      end
    join
    wait_drain();

    a_ordy = 1'b0;
    send_a(3'd1, 1'b1, 2'd0, 9'h002);
    send_a(3'd2, 1'b1, 2'd0, 9'h004);
    #3 rst_n = 1'b0;
    exp_a.delete();
    #1;
    chk(a_ovalid == 1'b0, "arst_out_valid", a_ovalid, 0);
    chk(a_dec == 8'h00, "arst_out_dec", a_dec, 0);
    chk(a_rdy == 1'b1, "arst_in_ready", a_rdy, 1);
    @(negedge clk); #2;
    rst_n = 1'b1;
    a_ordy = 1'b1;
    @(posedge clk); #1;
    send_a(3'd3, 1'b1, 2'd0, 9'h008);
    wait_drain();

    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          int c, m;
          bit e;
          c = $urandom_range(0, 7);
          m = $urandom_range(0, 3);
          e = ($urandom_range(0, 7) != 0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send_a(3'(c), e, 2'(m), ref_pat(c, e, m, 8));
        end
        rnd_on = 0;
      end
      begin
        int probes = 0;
        logic r0;
        while (rnd_on) begin
          @(posedge clk); #1;
          a_ordy = 1'($urandom_range(0, 1));
          if (probes < 200) begin
            r0 = a_rdy;
            a_ordy = ~a_ordy;
            #1;
            chk(a_rdy == r0, "in_ready_vs_out_ready", a_rdy, r0);
            a_ordy = ~a_ordy;
            probes++;
          end
        end
      end
    join
    a_ordy = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
